// File: rtl/fifo_sync_pkg.sv
// Shared types for the synchronous FIFO: the per-cycle operation that drives
// the occupancy counter.
package fifo_sync_pkg;

  // Encoded as {write_accepted, read_accepted} so a cast builds it directly.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data and count-derived full/empty
// flags. DEPTH need not be a power of two.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int DEPTH    = 8
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iEnW,
  input  logic                iEnR,
  input  logic                iClr,
  input  logic [BITWIDTH-1:0] iData,
  output logic [BITWIDTH-1:0] oData,
  output logic                oFull,
  output logic                oEmpty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BITWIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                wr_en;
  logic                rd_en;
  op_e                 op;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign oEmpty = (count == '0);
  assign oFull  = (count == CNT_W'(DEPTH));

  // Clear suppresses both transfers, so oData and storage are left untouched.
  assign wr_en = iEnW & ~oFull & ~iClr;
  assign rd_en = iEnR & ~oEmpty & ~iClr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    op = OP_IDLE;
    op = op_e'({wr_en, rd_en});
  end

  // NOTE: storage has no reset; only pointers and count define what is valid,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge iClk) begin
    if (wr_en) mem[wr_ptr] <= iData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iClr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      unique case (op)
        OP_WRITE: count <= count + CNT_W'(1);
        OP_READ:  count <= count - CNT_W'(1);
        default:  count <= count;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oData <= '0;
    end else if (rd_en) begin
      oData <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: directed vector table, hand-written
// corner sequences, and random traffic against a queue-based model.
module tb_fifo_sync;

  localparam int BW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_w, en_r, clr;
  logic [BW-1:0] din;
  logic [BW-1:0] dout;
  logic          full, empty;

  fifo_sync #(.BITWIDTH(BW), .DEPTH(DEPTH)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .iEnW  (en_w),
    .iEnR  (en_r),
    .iClr  (clr),
    .iData (din),
    .oData (dout),
    .oFull (full),
    .oEmpty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          w;
    logic          r;
    logic          c;
    logic [BW-1:0] d;
    logic [BW-1:0] exp_data;
    logic          exp_full;
    logic          exp_empty;
  } vec_t;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [BW-1:0] model_q[$];
  logic [BW-1:0] model_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " data"},  32'(dout),  32'(model_data));
    check({tag, " full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, " empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // Drive at a falling edge, let one rising edge act, return at the next
  // falling edge. The model follows the rules using the pre-edge occupancy.
  task automatic step(input logic w, input logic r, input logic c, input logic [BW-1:0] d);
    bit do_r, do_w;
    en_w = w; en_r = r; clr = c; din = d;
    @(posedge clk);
    if (c) begin
      model_q.delete();
    end else begin
      do_r = r && (model_q.size() > 0);
      do_w = w && (model_q.size() < DEPTH);
      if (do_r) model_data = model_q.pop_front();
      if (do_w) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  vec_t          vecs[20];
  logic [BW-1:0] fill_data[10];

  initial begin
    fill_data = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
    for (int i = 0; i < 10; i++) begin
      vecs[i] = '{w: 1'b1, r: 1'b0, c: 1'b0, d: fill_data[i],
                  exp_data: 8'h00, exp_full: (i >= 7), exp_empty: 1'b0};
    end
    for (int j = 0; j < 10; j++) begin
      vecs[10 + j] = '{w: 1'b0, r: 1'b1, c: 1'b0, d: 8'h00,
                       exp_data: fill_data[(j < 8) ? j : 7], exp_full: 1'b0,
                       exp_empty: (j >= 7)};
    end

    // Reset held from time zero, checked at 3 ns before any clock edge.
    rst_n = 1'b0; en_w = 1'b0; en_r = 1'b0; clr = 1'b0; din = '0;
    model_data = '0;
    #3;
    check("reset empty", 32'(empty), 32'd1);
    check("reset full",  32'(full),  32'd0);
    check("reset data",  32'(dout),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill with overflow, then drain with underflow.
    for (int k = 0; k < 20; k++) begin
      step(vecs[k].w, vecs[k].r, vecs[k].c, vecs[k].d);
      check($sformatf("vec%0d data", k),  32'(dout),  32'(vecs[k].exp_data));
      check($sformatf("vec%0d full", k),  32'(full),  32'(vecs[k].exp_full));
      check($sformatf("vec%0d empty", k), 32'(empty), 32'(vecs[k].exp_empty));
    end

    // Overlapped push/pop: reads start five cycles after writes.
    for (int c = 0; c < 15; c++) begin
      step(c < 10, c >= 5, 1'b0, 8'($urandom));
      check_model($sformatf("overlap%0d", c));
      check($sformatf("overlap%0d never full", c), 32'(full), 32'd0);
    end

    // Full with both requests: read performed, write dropped, seven remain.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    check("pre-both full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 1'b0, 8'hEE);
    check("full both data", 32'(dout), 32'h40);
    check("full both full", 32'(full), 32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("full both drain%0d", i), 32'(dout), 32'(8'h40 + i));
    end
    check("full both drained", 32'(empty), 32'd1);

    // Empty with both requests: write performed, oData holds, one entry.
    step(1'b1, 1'b1, 1'b0, 8'h77);
    check("empty both data", 32'(dout),  32'h47);
    check("empty both empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("empty both read", 32'(dout),  32'h77);
    check("empty both count1", 32'(empty), 32'd1);

    // Clear beats a concurrent write; FIFO remains usable afterwards.
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    step(1'b1, 1'b0, 1'b0, 8'hBB);
    step(1'b1, 1'b0, 1'b1, 8'hCC);
    check("clr empty", 32'(empty), 32'd1);
    check("clr data hold", 32'(dout), 32'h77);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("clr no read", 32'(dout), 32'h77);
    step(1'b1, 1'b0, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("post clr data", 32'(dout), 32'h5A);
    check("post clr empty", 32'(empty), 32'd1);

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(99) < 55), ($urandom_range(99) < 45),
           ($urandom_range(99) < 2), 8'($urandom));
      check_model($sformatf("rand%0d", c));
    end

    // Asynchronous reset mid-stream, taking effect between clock edges.
    step(1'b1, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 8'h22);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    en_w = 1'b0; en_r = 1'b0; clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst empty", 32'(empty), 32'd1);
    check("async rst full",  32'(full),  32'd0);
    check("async rst data",  32'(dout),  32'd0);
    model_q.delete();
    model_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_model("post rst read ignored");
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_model("post rst traffic");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
